// File: rtl/mul_mac_pipe.sv
// mul_mac_pipe: pipelined UU/SU/US/SS int/frac multiply-accumulate with rounding, saturation, dual MR banks and slice transfers
module mul_mac_pipe #(
  parameter int RF_DATASIZE = 16,
  parameter int GUARD = RF_DATASIZE / 2,
  parameter int PIPE_STAGES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RF_DATASIZE-1:0] xb_dtx,
  input  logic [RF_DATASIZE-1:0] xb_dty,
  input  logic                   ps_mul_en,
  input  logic                   ps_mul_otreg,
  input  logic [3:0]             ps_mul_dtsts,
  input  logic [1:0]             ps_mul_cls,
  input  logic [1:0]             ps_mul_sc,
  input  logic                   ps_mul_mrsel,
  input  logic                   ps_mul_clrsticky,
  output logic [RF_DATASIZE-1:0] mul_xb_dt,
  output logic                   mul_ps_valid,
  output logic                   mul_ps_mv,
  output logic                   mul_ps_mn,
  output logic                   mul_ps_mvs
);
  localparam int W = RF_DATASIZE;
  localparam int MRW = 2 * W + GUARD;
  localparam int D = PIPE_STAGES > 0 ? PIPE_STAGES : 1;
  typedef struct packed {
    logic v;
    logic otreg;
    logic [2:0] typ;
    logic [1:0] cls;
    logic [1:0] sc;
    logic mrsel;
    logic [W-1:0] x;
  } ctl_t;
  ctl_t e0, ea;
  ctl_t cs [D];
  logic [MRW-1:0] ps [D];
  logic [W-1:0] e0_y, rd;
  logic e0_rnd, sat, xfer, sgn, frac, mv;
  logic signed [W:0] xe, ye;
  logic signed [2*W:0] full;
  logic [2*W-1:0] p_sel, p_add, p_fin;
  logic [MRW-1:0] prod, ea_p, mrf, mrb, cur, out, sat_val, wr;
  function automatic logic ovf(input logic [MRW-1:0] v, input logic s, input logic f);
    logic [MRW-W:0] si;
    logic [GUARD:0] sf;
    si = v[MRW-1:W-1];
    sf = v[MRW-1:2*W-1];
    return f ? (s ? !(&sf || !(|sf)) : |v[MRW-1:2*W]) : (s ? !(&si || !(|si)) : |v[MRW-1:W]);
  endfunction
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      e0 <= '0;
      e0_y <= '0;
      e0_rnd <= 1'b0;
    end else if (ps_mul_en) begin
      e0 <= {1'b1, ps_mul_otreg, ps_mul_dtsts[3:1], ps_mul_cls, ps_mul_sc, ps_mul_mrsel, xb_dtx};
      e0_y <= xb_dty;
      e0_rnd <= ps_mul_dtsts[0];
    end else begin
      e0.v <= 1'b0;
    end
  assign xe = {e0.typ[1] & e0.x[W-1], e0.x};
  assign ye = {e0.typ[2] & e0_y[W-1], e0_y};
  assign full = (2*W+1)'(xe) * (2*W+1)'(ye);
  assign p_sel = &e0.typ ? {full[2*W-2:0], 1'b0} : full[2*W-1:0];
  assign p_add = p_sel + ((2*W)'(1) << (W - 1));
  assign p_fin = e0_rnd && e0.typ[0] ? {p_add[2*W-1:W], {W{1'b0}}} : p_sel;
  assign prod = {{GUARD{|e0.typ[2:1] & full[2*W]}}, p_fin};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < D; i++) begin
        cs[i] <= '0;
        ps[i] <= '0;
      end
    end else begin
      cs[0] <= e0;
      ps[0] <= prod;
      for (int i = 1; i < D; i++) begin
        cs[i] <= cs[i-1];
        ps[i] <= ps[i-1];
      end
    end
  assign ea = PIPE_STAGES == 0 ? e0 : cs[D-1];
  assign ea_p = PIPE_STAGES == 0 ? prod : ps[D-1];
  always_comb begin
    cur = ea.mrsel ? mrb : mrf;
    sat = ea.cls == 2'b00 && ea.sc == 2'b11;
    xfer = ea.cls == 2'b00 && !sat;
    sgn = sat ? ea.typ[1] : |ea.typ[2:1];
    frac = ea.typ[0];
    sat_val = frac ? (sgn ? {{(GUARD+1){cur[MRW-1]}}, {(2*W-1){!cur[MRW-1]}}} : {{GUARD{1'b0}}, {(2*W){1'b1}}})
                   : (sgn ? {{(MRW-W+1){cur[MRW-1]}}, {(W-1){!cur[MRW-1]}}} : {{(MRW-W){1'b0}}, {W{1'b1}}});
    wr = ea.sc == 2'b00 ? {cur[MRW-1:W], ea.x}
       : ea.sc == 2'b01 ? {{GUARD{ea.x[W-1]}}, ea.x, cur[W-1:0]}
       : {ea.x[GUARD-1:0], cur[2*W-1:0]};
    rd = ea.sc == 2'b00 ? cur[W-1:0]
       : ea.sc == 2'b01 ? cur[2*W-1:W]
       : {{(W-GUARD){cur[MRW-1]}}, cur[MRW-1:2*W]};
    out = ea.cls == 2'b01 ? ea_p
        : ea.cls == 2'b10 ? cur + ea_p
        : ea.cls == 2'b11 ? cur - ea_p
        : sat ? (ovf(cur, sgn, frac) ? sat_val : cur)
        : wr;
    mv = ea.v && !xfer && ovf(out, sgn, frac);
  end
  assign mul_ps_valid = ea.v;
  assign mul_xb_dt = !ea.v ? '0 : xfer && !ea.otreg ? rd : frac ? out[2*W-1:W] : out[W-1:0];
  assign mul_ps_mv = mv;
  assign mul_ps_mn = ea.v && !xfer && |ea.typ[2:1] && out[MRW-1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mrf <= '0;
      mrb <= '0;
      mul_ps_mvs <= 1'b0;
    end else begin
      if (ea.v && ea.otreg && !ea.mrsel) mrf <= out;
      if (ea.v && ea.otreg && ea.mrsel) mrb <= out;
      mul_ps_mvs <= mv ? 1'b1 : ps_mul_clrsticky ? 1'b0 : mul_ps_mvs;
    end
endmodule

// File: tb/tb_mul_mac_pipe.sv
// tb_mul_mac_pipe: scoreboard bench for mul_mac_pipe against an arithmetic reference model
module tb_mul_mac_pipe;
  localparam int P = 1;
  localparam longint M32 = 64'hFFFF_FFFF;
  localparam longint M40 = 64'hFF_FFFF_FFFF;
  logic clk = 0, reset = 0;
  logic [15:0] xb_dtx = 0, xb_dty = 0, mul_xb_dt;
  logic ps_mul_en = 0, ps_mul_otreg = 0, ps_mul_mrsel = 0, ps_mul_clrsticky = 0;
  logic [3:0] ps_mul_dtsts = 0;
  logic [1:0] ps_mul_cls = 0, ps_mul_sc = 0;
  logic mul_ps_valid, mul_ps_mv, mul_ps_mn, mul_ps_mvs;
  mul_mac_pipe #(.RF_DATASIZE(16), .GUARD(8), .PIPE_STAGES(P)) dut (
    .clk(clk), .reset(reset), .xb_dtx(xb_dtx), .xb_dty(xb_dty), .ps_mul_en(ps_mul_en),
    .ps_mul_otreg(ps_mul_otreg), .ps_mul_dtsts(ps_mul_dtsts), .ps_mul_cls(ps_mul_cls),
    .ps_mul_sc(ps_mul_sc), .ps_mul_mrsel(ps_mul_mrsel), .ps_mul_clrsticky(ps_mul_clrsticky),
    .mul_xb_dt(mul_xb_dt), .mul_ps_valid(mul_ps_valid), .mul_ps_mv(mul_ps_mv),
    .mul_ps_mn(mul_ps_mn), .mul_ps_mvs(mul_ps_mvs)
  );
  always #5 clk = ~clk;
  typedef struct {
    int cyc;
    logic [15:0] dt;
    bit chk_dt;
    bit mv;
    bit mn;
  } exp_t;
  exp_t q[$];
  longint mr[2];
  int cyc = 0, errors = 0, checks = 0;
  bit exp_mvs = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string n, longint a, longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", n, a, e, cyc);
    end
  endfunction
  function automatic longint sx40(longint v);
    return v >= (longint'(1) << 39) ? v - (longint'(1) << 40) : v;
  endfunction
  function automatic bit model_mv(longint v, bit s, bit f);
    longint lim;
    if (!s) return (v >> (f ? 32 : 16)) != 0;
    lim = longint'(1) << (f ? 31 : 15);
    return sx40(v) < -lim || sx40(v) >= lim;
  endfunction
  function automatic longint model_prod(logic [15:0] x, logic [15:0] y, logic [3:0] d);
    longint xv, yv, p, p2;
    xv = d[2] ? longint'($signed(x)) : longint'(x);
    yv = d[3] ? longint'($signed(y)) : longint'(y);
    p = xv * yv;
    p2 = ((d[3] && d[2] && d[1]) ? p * 2 : p) & M32;
    if (d[1] && d[0]) p2 = ((p2 + 32768) & M32) & ~longint'(16'hFFFF);
    return ((d[3] || d[2]) && p < 0) ? (p2 | (longint'(8'hFF) << 32)) : p2;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    bit cur_mv;
    if (!reset) exp_mvs = 0;
    else begin
      cur_mv = 0;
      chk("mvs", mul_ps_mvs, exp_mvs);
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("valid", mul_ps_valid, 1);
        if (e.chk_dt) chk("data", mul_xb_dt, e.dt);
        chk("mv", mul_ps_mv, e.mv);
        chk("mn", mul_ps_mn, e.mn);
        cur_mv = e.mv;
      end else chk("idle_valid", mul_ps_valid, 0);
      exp_mvs = cur_mv ? 1 : ps_mul_clrsticky ? 0 : exp_mvs;
    end
  end
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input bit ot, input logic [3:0] d,
                       input logic [1:0] cls, input logic [1:0] sc, input bit sel, input bit clr = 0);
    exp_t e;
    longint cur, pr, o, satv, g;
    bit sat, xfer, sg, f;
    int k;
    logic [15:0] rd;
    @(posedge clk);
    #1;
    ps_mul_en = 1; xb_dtx = x; xb_dty = y; ps_mul_otreg = ot; ps_mul_dtsts = d;
    ps_mul_cls = cls; ps_mul_sc = sc; ps_mul_mrsel = sel; ps_mul_clrsticky = clr;
    cur = mr[sel];
    pr = model_prod(x, y, d);
    sat = cls == 0 && sc == 3;
    xfer = cls == 0 && sc != 3;
    sg = sat ? d[2] : (d[3] | d[2]);
    f = d[1];
    k = f ? 31 : 15;
    satv = !sg ? (f ? M32 : 64'hFFFF) : (sx40(cur) < 0 ? (-(longint'(1) << k)) & M40 : (longint'(1) << k) - 1);
    g = (cur >> 32) & 64'hFF;
    rd = sc == 0 ? 16'(cur & 64'hFFFF) : sc == 1 ? 16'((cur >> 16) & 64'hFFFF) : 16'(g >= 128 ? g | 64'hFF00 : g);
    if (cls == 1) o = pr;
    else if (cls == 2) o = (cur + pr) & M40;
    else if (cls == 3) o = (cur - pr) & M40;
    else if (sat) o = model_mv(cur, sg, f) ? satv : cur;
    else if (sc == 0) o = (cur & ~longint'(16'hFFFF)) | longint'(x);
    else if (sc == 1) o = (cur & 64'hFFFF) | ((longint'($signed(x)) << 16) & M40);
    else o = (cur & M32) | (longint'(x & 16'hFF) << 32);
    e.dt = (xfer && !ot) ? rd : f ? 16'((o >> 16) & 64'hFFFF) : 16'(o & 64'hFFFF);
    e.chk_dt = !ot;
    e.mv = !xfer && model_mv(o, sg, f);
    e.mn = !xfer && (d[3] || d[2]) && ((o >> 39) & 1) == 1;
    e.cyc = cyc + 1 + P;
    if (ot) mr[sel] = o;
    q.push_back(e);
  endtask
  task automatic idle(input int n, input bit clr = 0);
    repeat (n) begin
      @(posedge clk);
      #1;
      ps_mul_en = 0;
      ps_mul_clrsticky = clr;
    end
  endtask
  task automatic read_all(input bit sel);
    for (int s = 0; s < 3; s++) issue(16'h0, 16'h0, 0, 4'b0000, 2'b00, 2'(s), sel);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int vc;
    mr[0] = 0;
    mr[1] = 0;
    @(negedge clk);
    chk("rst_dt", mul_xb_dt, 0);
    chk("rst_valid", mul_ps_valid, 0);
    chk("rst_mv", mul_ps_mv, 0);
    chk("rst_mn", mul_ps_mn, 0);
    chk("rst_mvs", mul_ps_mvs, 0);
    @(posedge clk);
    #1 reset = 1;
    issue(16'h4000, 16'h4000, 0, 4'b1110, 2'b01, 2'b00, 0);
    issue(16'hFFFF, 16'hFFFF, 1, 4'b0000, 2'b01, 2'b00, 0);
    read_all(0);
    repeat (3) issue(16'h0002, 16'h0003, 1, 4'b1100, 2'b10, 2'b00, 1);
    issue(16'h0, 16'h0, 0, 4'b0000, 2'b00, 2'b00, 1);
    issue(16'h0, 16'h0, 0, 4'b0000, 2'b00, 2'b00, 0);
    for (int s = 0; s < 3; s++) issue(16'h0, 16'h0, 1, 4'b0000, 2'b00, 2'(s), 0);
    issue(16'h0001, 16'h0001, 1, 4'b1100, 2'b11, 2'b00, 0);
    read_all(0);
    issue(16'h0000, 16'h0, 1, 4'b0000, 2'b00, 2'b00, 0);
    issue(16'h0000, 16'h0, 1, 4'b0000, 2'b00, 2'b01, 0);
    issue(16'h0001, 16'h0, 1, 4'b0000, 2'b00, 2'b10, 0);
    issue(16'h0, 16'h0, 1, 4'b0110, 2'b00, 2'b11, 0);
    read_all(0);
    issue(16'h8000, 16'h8000, 0, 4'b1111, 2'b01, 2'b00, 0);
    issue(16'hFFFF, 16'h0001, 0, 4'b1111, 2'b01, 2'b00, 0);
    idle(3, 1);
    idle(2);
    issue(16'hFFFF, 16'hFFFF, 0, 4'b0000, 2'b01, 2'b00, 0);
    idle(2);
    issue(16'hFFFF, 16'hFFFF, 0, 4'b0000, 2'b01, 2'b00, 0);
    idle(1);
    idle(1, 1);
    idle(2);
    idle(1, 1);
    idle(3);
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(4) == 0) idle(1, $urandom_range(7) == 0);
      else issue(16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom), 2'($urandom), 2'($urandom),
                 1'($urandom), $urandom_range(7) == 0);
    end
    read_all(0);
    read_all(1);
    issue(16'hFFFF, 16'hFFFF, 1, 4'b0000, 2'b01, 2'b00, 0);
    issue(16'h1234, 16'h5678, 1, 4'b1100, 2'b10, 2'b00, 1);
    @(posedge clk);
    #1;
    ps_mul_en = 0;
    reset = 0;
    q.delete();
    mr[0] = 0;
    mr[1] = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    vc = 0;
    repeat (6) @(negedge clk) vc += int'(mul_ps_valid);
    chk("post_reset_valid", vc, 0);
    read_all(0);
    read_all(1);
    idle(P + 4);
    chk("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mul_mac_pipe.md
# mul_mac_pipe

Parametrised, pipelined successor to the execute-unit multiplier. Performs UU/SU/US/SS integer and fractional multiplies, optional rounding, multiply-accumulate (add/sub) and saturation into one of two foreground/background accumulators (MRF/MRB), plus Rn<->MRx slice transfers. Sits beside the ALU and shifter and is driven by program-sequencer decode. Operands come from the register-file crossbar, and results return on the same crossbar with a valid strobe.

## Interface
- RF_DATASIZE, 16, operand/result width (even, >=8)
- GUARD, RF_DATASIZE/2, accumulator guard bits; MRW = 2*RF_DATASIZE+GUARD
- PIPE_STAGES, 1, product register stages between operand latch and accumulate stage (0..3)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- xb_dtx, xb_dty  in  RF_DATASIZE  Rx/Ry operands from crossbar
- ps_mul_en  in  1  issue strobe; control/operands sampled on the edge where high
- ps_mul_otreg  in  1  0 = result to Rn, 1 = result to MR
- ps_mul_dtsts  in  4  {ryS, rxS, IbF(1 = fractional), rnd}; rxS also selects MR signedness for SAT
- ps_mul_cls  in  2  00 transfer/SAT, 01 product, 10 MR+=, 11 MR-=
- ps_mul_sc  in  2  with cls 00: 00 MR0, 01 MR1, 10 MR2, 11 SAT MR
- ps_mul_mrsel  in  1  0 = MRF, 1 = MRB
- ps_mul_clrsticky  in  1  clears mul_ps_mvs
- mul_xb_dt  out  RF_DATASIZE  result to crossbar
- mul_ps_valid  out  1  mul_xb_dt and flags valid this cycle
- mul_ps_mv, mul_ps_mn  out  1  overflow and sign flags, qualified by valid
- mul_ps_mvs  out  1  sticky overflow

## Operation
- Stage E0 (issue edge): latch control, mrsel, xb_dtx and xb_dty when ps_mul_en=1. No-op bubbles propagate with valid=0.
- Product: signed operands sign-extended and unsigned operands zero-extended to RF_DATASIZE+1 bits, then full multiply.
- 2*RF_DATASIZE product selection:
  - SS fractional: product shifted left 1 (redundant sign dropped).
  - All other cases: low 2*RF_DATASIZE bits of the exact product.
- Rounding (rnd=1, fractional only): add 2^(RF_DATASIZE-1), then clear bits [RF_DATASIZE-1:0].
- Extension to MRW: sign-extend if either operand is signed and the product is negative; otherwise zero-extend.
- Product and sign travel through PIPE_STAGES registers, followed by the final stage EA.
- EA, cls=01: out = product.
- EA, cls=1x: out = MR[mrsel] ± product, modulo 2^MRW.
- EA, cls=00, sc 00..10:
  - otreg=1 writes Rx into slice MRx of MR[mrsel]: MR0 raw; MR1 sign-extended into the guard bits; MR2 = low GUARD bits.
  - otreg=0 reads the slice to Rn; MR2 is sign-extended to RF_DATASIZE.
- EA, SAT: on overflow, clamp MR[mrsel] per mode; otherwise leave it unchanged.
  - UI: 2^RF_DATASIZE-1.
  - SI: sign-extended signed RF_DATASIZE max/min.
  - UF: 2^(2*RF_DATASIZE)-1.
  - SF: sign-extended signed 2*RF_DATASIZE max/min.
- MR[mrsel] is written only when otreg=1 and EA is valid. The other bank is never touched.
- Rn result: IbF=1 gives out[2*RF_DATASIZE-1:RF_DATASIZE], else out[RF_DATASIZE-1:0]. Slice reads return the slice.
- mv (mode-dependent, on out):
  - UI: [MRW-1:RF_DATASIZE] nonzero.
  - UF: [MRW-1:2*RF_DATASIZE] nonzero.
  - SI: [MRW-1:RF_DATASIZE-1] not all equal.
  - SF: [MRW-1:2*RF_DATASIZE-1] not all equal.
- mn = (either operand signed) & out[MRW-1].
- mv and mn are forced to 0 for slice transfers and whenever valid=0.
- mvs sets on any valid mv=1 and clears on ps_mul_clrsticky. Set wins if both occur in the same cycle.

## Timing
- Reset: all pipeline registers, MRF, MRB and mvs clear. Outputs mul_xb_dt=0, valid=0, mv=0, mn=0, mvs=0.
- Latency: an op issued with ps_mul_en=1 at edge k presents its result, with valid=1, in the cycle after edge k+PIPE_STAGES. The MR update occurs at edge k+PIPE_STAGES+1.
- Fully pipelined: one issue per cycle. Ops complete in issue order with no stalls.
- Back-to-back accumulates to the same bank: each accumulate uses the MR value including all earlier ops. Only EA reads MR, so no forwarding is needed.
- A slice read issued right after an accumulate returns the post-accumulate value.
- Reset asserted mid-operation discards in-flight ops. valid stays 0 until new issues reach EA.
- Accumulator wrap: the sum is modulo 2^MRW with no implicit saturation. mv reports the condition.

## Test plan
- RF=16, PIPE=1, SSF, rnd=0: Rx=0x4000, Ry=0x4000, cls=01, otreg=0 → mul_xb_dt=0x2000 and valid=1 two cycles after the issue edge; mv=0, mn=0.
- UUI, cls=01, otreg=1: 0xFFFF*0xFFFF → MRF=0x00_FFFE_0001; mv=1 (UI).
- Back-to-back MR+= on MRB, SSI, 3x (0x0002*0x0003) → MRB=18, MRF unchanged. Then MR0 read → 0x0012.
- MR-= from MRF=0, SSI, 1*1 → MRF=0xFF_FFFF_FFFF, mn=1. Then SAT with SF on MRF=0x01_0000_0000 → MRF=0x00_7FFF_FFFF.
- Overflowing op, then ps_mul_clrsticky asserted together with a second overflowing op → mvs stays 1. Clear with no valid op → mvs=0.
- Reset pulsed while 2 ops are in flight → no valid pulse afterwards, MRF=MRB=0.
